// File: rtl/l2_pkg.sv
// ---------------------------------------------------------------------------
// l2_pkg
//   Shared types and defaults for the L2 metadata storage arrays.
//   - l2_clr_state_t : clear-sweep controller state (idle / sweeping)
//   - L2_DEF_S_INDEX : default set-index width
//   - L2_DEF_WIDTH   : default entry width
// ---------------------------------------------------------------------------
package l2_pkg;

  typedef enum logic {
    L2_CLR_IDLE,
    L2_CLR_SWEEP
  } l2_clr_state_t;

  localparam int L2_DEF_S_INDEX = 3;
  localparam int L2_DEF_WIDTH   = 1;

endpackage : l2_pkg

// File: rtl/l2_clr_array.sv
// ---------------------------------------------------------------------------
// l2_clr_array
//   2**S_INDEX x WIDTH storage array for L2 metadata (valid, dirty, tag, LRU).
//   Combinational read, same-cycle write-to-read bypass, per-bit write mask.
//   Contents are brought to CLR_VAL by a synchronous sweep, one set per clock,
//   started by reset or by a run-time clear request.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset; restarts the clear sweep
//   read       read enable (dataout is 0 when low)
//   load       write enable (ignored while sweeping or when clear_req is high)
//   rindex     read set index
//   windex     write set index
//   datain     write data
//   wmask      per-bit write enable, 1 = bit written
//   clear_req  single-cycle request to start a clear sweep (idle only)
//   busy       high while a sweep is in progress
//   dataout    combinational read data
// ---------------------------------------------------------------------------
module l2_clr_array
  import l2_pkg::*;
#(
  parameter int               S_INDEX = L2_DEF_S_INDEX,
  parameter int               WIDTH   = L2_DEF_WIDTH,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               read,
  input  logic               load,
  input  logic [S_INDEX-1:0] rindex,
  input  logic [S_INDEX-1:0] windex,
  input  logic [WIDTH-1:0]   datain,
  input  logic [WIDTH-1:0]   wmask,
  input  logic               clear_req,
  output logic               busy,
  output logic [WIDTH-1:0]   dataout
);

  localparam int NUM_SETS = 1 << S_INDEX;

  // All-ones index is the last set; the counter wraps to 0 naturally after it.
  localparam logic [S_INDEX-1:0] LAST_IDX = '1;

  (* ramstyle = "logic" *) logic [WIDTH-1:0] data [NUM_SETS];

  l2_clr_state_t      state_reg, state_next;
  logic [S_INDEX-1:0] clr_idx_reg, clr_idx_next;

  logic               wr_en;
  logic [S_INDEX-1:0] wr_idx;
  logic [WIDTH-1:0]   wr_data;

  logic [WIDTH-1:0]   wr_old;
  logic [WIDTH-1:0]   wr_merge;
  logic               byp_hit;

  // -------------------------------------------------------------------------
  // Masked merge of new data into the entry currently at windex. The same
  // word serves as the bypass value, since bypass only applies when
  // rindex == windex.
  // -------------------------------------------------------------------------
  assign wr_old = data[windex];

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_merge
      assign wr_merge[gi] = wmask[gi] ? datain[gi] : wr_old[gi];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Sweep controller: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= L2_CLR_SWEEP;
      clr_idx_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_idx_reg <= clr_idx_next;
    end
  end

  // -------------------------------------------------------------------------
  // Sweep controller: next state and the single array write port select.
  // The sweep owns the write port; user loads are dropped, not queued.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    clr_idx_next = clr_idx_reg;
    wr_en        = 1'b0;
    wr_idx       = windex;
    wr_data      = wr_merge;

    case (state_reg)
      L2_CLR_SWEEP: begin
        wr_en        = 1'b1;
        wr_idx       = clr_idx_reg;
        wr_data      = CLR_VAL;
        clr_idx_next = clr_idx_reg + S_INDEX'(1);
        if (clr_idx_reg == LAST_IDX) begin
          state_next = L2_CLR_IDLE;
        end
      end
      L2_CLR_IDLE: begin
        if (clear_req) begin
          state_next   = L2_CLR_SWEEP;
          clr_idx_next = '0;
        end else if (load) begin
          wr_en = 1'b1;
        end
      end
      default: begin
        state_next   = L2_CLR_SWEEP;
        clr_idx_next = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Storage write. Reset suppresses the write so a reset edge never commits
  // a sweep step or a load.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      data[wr_idx] <= wr_data;
    end
  end

  // -------------------------------------------------------------------------
  // Read path. While sweeping, every entry is logically CLR_VAL even if the
  // counter has not reached it yet, so reads return CLR_VAL directly.
  // -------------------------------------------------------------------------
  assign busy    = (state_reg == L2_CLR_SWEEP);
  assign byp_hit = load && !clear_req && (rindex == windex);

  always_comb begin
    dataout = '0;
    if (read) begin
      if (busy) begin
        dataout = CLR_VAL;
      end else if (byp_hit) begin
        dataout = wr_merge;
      end else begin
        dataout = data[rindex];
      end
    end
  end

endmodule : l2_clr_array

// File: tb/tb_l2_clr_array.sv
// ---------------------------------------------------------------------------
// tb_l2_clr_array
//   Randomised and directed stimulus for l2_clr_array (S_INDEX=3, WIDTH=4,
//   CLR_VAL=4'hA) checked against a behavioural model: a sweep is treated as
//   "all sets become CLR_VAL, busy for NUM_SETS further edges".
// ---------------------------------------------------------------------------
module tb_l2_clr_array;

  localparam int         S_INDEX  = 3;
  localparam int         WIDTH    = 4;
  localparam int         NUM_SETS = 8;
  localparam logic [3:0] CLR_VAL  = 4'hA;

  logic       clk;
  logic       rst_n;
  logic       read;
  logic       load;
  logic [2:0] rindex;
  logic [2:0] windex;
  logic [3:0] datain;
  logic [3:0] wmask;
  logic       clear_req;
  logic       busy;
  logic [3:0] dataout;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state
  logic [3:0] m_mem [NUM_SETS];
  logic       m_busy;
  int         m_left;     // sweep edges still to go
  logic       m_valid;    // model known after first reset edge

  l2_clr_array #(
    .S_INDEX (S_INDEX),
    .WIDTH   (WIDTH),
    .CLR_VAL (CLR_VAL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .read      (read),
    .load      (load),
    .rindex    (rindex),
    .windex    (windex),
    .datain    (datain),
    .wmask     (wmask),
    .clear_req (clear_req),
    .busy      (busy),
    .dataout   (dataout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [3:0] merge(input logic [3:0] d, input logic [3:0] m,
                                       input logic [3:0] old);
    return (d & m) | (old & ~m);
  endfunction

  function automatic logic [3:0] exp_dout();
    if (!read)                                       return 4'h0;
    if (m_busy)                                      return CLR_VAL;
    if (load && !clear_req && rindex == windex)      return merge(datain, wmask, m_mem[windex]);
    return m_mem[rindex];
  endfunction

  // One clock of stimulus: drive, check combinational outputs mid-cycle,
  // take the edge, advance the model.
  task automatic step(input logic rn, input logic rd, input logic ld,
                      input logic [2:0] ri, input logic [2:0] wi,
                      input logic [3:0] d, input logic [3:0] m, input logic cr);
    rst_n = rn; read = rd; load = ld; rindex = ri; windex = wi;
    datain = d; wmask = m; clear_req = cr;
    #4;
    if (m_valid) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("dout", 32'(dataout), 32'(exp_dout()));
    end
    $display("cyc=%0d rst_n=%b rd=%b ld=%b ri=%0d wi=%0d d=%h m=%h clr=%b busy=%b dout=%h",
             cyc, rn, rd, ld, ri, wi, d, m, cr, busy, dataout);
    @(posedge clk);
    cyc++;
    if (!rn) begin
      m_valid = 1'b1;
      m_busy  = 1'b1;
      m_left  = NUM_SETS;
      for (int i = 0; i < NUM_SETS; i++) m_mem[i] = CLR_VAL;
    end else if (m_valid) begin
      if (m_busy) begin
        m_left--;
        if (m_left == 0) m_busy = 1'b0;
      end else if (cr) begin
        m_busy = 1'b1;
        m_left = NUM_SETS;
        for (int i = 0; i < NUM_SETS; i++) m_mem[i] = CLR_VAL;
      end else if (ld) begin
        m_mem[wi] = merge(d, m, m_mem[wi]);
      end
    end
    #1;
  endtask

  task automatic idle_rd(input logic [2:0] ri);
    step(1'b1, 1'b1, 1'b0, ri, 3'd0, 4'h0, 4'h0, 1'b0);
  endtask

  initial begin
    m_valid = 1'b0;
    m_busy  = 1'b0;
    m_left  = 0;
    rst_n = 1'b0; read = 1'b0; load = 1'b0; rindex = '0; windex = '0;
    datain = '0; wmask = '0; clear_req = 1'b0;
    #1;

    // Reset sweep: rst_n low two cycles, then a load attempt at sweep edge 3.
    step(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 4'h0, 4'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 4'h0, 4'h0, 1'b0);
    for (int i = 0; i < NUM_SETS; i++) begin
      if (i == 2) step(1'b1, 1'b1, 1'b1, 3'd3, 3'd3, 4'h1, 4'hF, 1'b0);
      else        idle_rd(3'(i));
    end
    chk("reset_busy_end", 32'(busy), 32'd0);
    for (int i = 0; i < NUM_SETS; i++) idle_rd(3'(i));

    // Masked write with same-cycle bypass on set 5 (holds 4'hA).
    rindex = 3'd5; windex = 3'd5; datain = 4'h5; wmask = 4'b0011; load = 1'b1;
    read = 1'b1; clear_req = 1'b0; rst_n = 1'b1;
    #1;
    chk("bypass_9", 32'(dataout), 32'h9);
    step(1'b1, 1'b1, 1'b1, 3'd5, 3'd5, 4'h5, 4'b0011, 1'b0);
    idle_rd(3'd5);
    chk("after_write_9", 32'(dataout), 32'h9);

    // Run-time clear with a colliding load.
    for (int i = 0; i < NUM_SETS; i++) step(1'b1, 1'b1, 1'b1, 3'(i), 3'(i), 4'h3, 4'hF, 1'b0);
    step(1'b1, 1'b1, 1'b1, 3'd2, 3'd2, 4'h7, 4'hF, 1'b1);
    for (int i = 0; i < NUM_SETS; i++) idle_rd(3'(i));
    for (int i = 0; i < NUM_SETS; i++) idle_rd(3'(i));

    // Reset mid-sweep.
    step(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 4'h0, 4'h0, 1'b1);
    for (int i = 0; i < 3; i++) idle_rd(3'(i));
    step(1'b0, 1'b1, 1'b0, 3'd4, 3'd0, 4'h0, 4'h0, 1'b0);
    for (int i = 0; i < NUM_SETS; i++) idle_rd(3'(i));
    for (int i = 0; i < NUM_SETS; i++) idle_rd(3'(i));

    // Read disabled / mismatched index.
    step(1'b1, 1'b1, 1'b1, 3'd2, 3'd2, 4'h6, 4'hF, 1'b0);
    step(1'b1, 1'b0, 1'b1, 3'd2, 3'd1, 4'h1, 4'hF, 1'b0);
    step(1'b1, 1'b1, 1'b1, 3'd2, 3'd1, 4'hC, 4'hF, 1'b0);
    step(1'b1, 1'b1, 1'b1, 3'd3, 3'd3, 4'hF, 4'h0, 1'b0);

    // clear_req during a sweep must not extend it.
    step(1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 4'h0, 4'h0, 1'b1);
    for (int i = 0; i < NUM_SETS; i++) begin
      if (i == 5) step(1'b1, 1'b1, 1'b0, 3'(i), 3'd0, 4'h0, 4'h0, 1'b1);
      else        idle_rd(3'(i));
    end
    chk("no_extend", 32'(busy), 32'd0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 2) != 0),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           4'($urandom), 4'($urandom),
           ($urandom_range(0, 39) == 0));
    end
    for (int i = 0; i < NUM_SETS + 1; i++) idle_rd(3'(i % NUM_SETS));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_l2_clr_array
